// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light lamp monitor: light codes,
// fault causes, monitor states and the legal colour-step rule.
package tlc_pkg;

  localparam int NUM_LANES = 3;

  localparam logic [1:0] LC_GREEN   = 2'd0;
  localparam logic [1:0] LC_YELLOW  = 2'd1;
  localparam logic [1:0] LC_RED     = 2'd2;
  localparam logic [1:0] LC_ILLEGAL = 2'd3;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_ILLEGAL  = 3'd1;
  localparam logic [2:0] FC_CONFLICT = 3'd2;
  localparam logic [2:0] FC_BAD_SEQ  = 3'd3;
  localparam logic [2:0] FC_SHORT_Y  = 3'd4;
  localparam logic [2:0] FC_SHORT_G  = 3'd5;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  // Only green->yellow, yellow->red and red->green are legal colour changes.
  function automatic logic legal_step(input logic [1:0] from, input logic [1:0] to);
    return ((from == LC_GREEN)  && (to == LC_YELLOW)) ||
           ((from == LC_YELLOW) && (to == LC_RED))    ||
           ((from == LC_RED)    && (to == LC_GREEN));
  endfunction

endpackage

// File: rtl/tlc_approach_checker.sv
// Per-approach checker: remembers the previous registered code and how long
// it has been held, and flags illegal codes, bad steps and short phases.
module tlc_approach_checker
  import tlc_pkg::*;
#(
  parameter int MIN_GREEN  = 8,
  parameter int MIN_YELLOW = 4,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hold,      // keep duration counter at 1 (monitor idle)
  input  logic [1:0] code_i,    // registered code for this approach
  output logic       illegal,
  output logic       bad_seq,
  output logic       short_y,
  output logic       short_g,
  output logic       not_red
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_G_C = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MIN_Y_C = CNT_W'(MIN_YELLOW);

  logic [1:0]       prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             changed;

  assign changed = (code_i != prev_q);

  // cnt_q is the number of cycles prev_q has been held, so at a change it
  // is the full duration of the phase being left.
  always_comb begin
    prev_d = code_i;
    cnt_d  = cnt_q;
    if (hold || changed)       cnt_d = CNT_ONE;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
  end

  // Previous code and duration state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= LC_RED;
      cnt_q  <= CNT_ONE;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

  assign illegal = (code_i == LC_ILLEGAL);
  assign not_red = (code_i != LC_RED);
  assign bad_seq = changed && !legal_step(prev_q, code_i);
  assign short_y = changed && (prev_q == LC_YELLOW) && (code_i == LC_RED)    && (cnt_q < MIN_Y_C);
  assign short_g = changed && (prev_q == LC_GREEN)  && (code_i == LC_YELLOW) && (cnt_q < MIN_G_C);

endmodule

// File: rtl/tlc_lamp_monitor.sv
// Lamp monitor top: registers the light codes, runs the per-approach
// checkers, latches the first fault cause and drives lamps (flashing red
// while faulted).
module tlc_lamp_monitor
  import tlc_pkg::*;
#(
  parameter int MIN_GREEN  = 8,
  parameter int MIN_YELLOW = 4,
  parameter int FLASH_HALF = 8,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] TL1,
  input  logic [1:0] TL2,
  input  logic [1:0] TL3,
  input  logic       fault_clr,
  output logic [2:0] lamp_g,
  output logic [2:0] lamp_y,
  output logic [2:0] lamp_r,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam logic [CNT_W-1:0] FLASH_HALF_C = CNT_W'(FLASH_HALF);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  logic [NUM_LANES-1:0][1:0] s1_q, s1_d;
  logic [NUM_LANES-1:0]      illegal, bad_seq, short_y, short_g, not_red;
  logic [NUM_LANES-1:0]      dec_g, dec_y, dec_r;
  logic                      all_red, conflict;
  int                        nr_cnt;
  logic [2:0]                cause;

  state_e                    state_q, state_d;
  logic                      fault_q, fault_d;
  logic [2:0]                fault_code_q, fault_code_d;
  logic [2:0]                lamp_g_q, lamp_g_d, lamp_y_q, lamp_y_d, lamp_r_q, lamp_r_d;
  logic [CNT_W-1:0]          flash_cnt_q, flash_cnt_d;
  logic                      flash_on_q, flash_on_d;

  assign s1_d = {TL3, TL2, TL1};

  // One checker and one lamp decoder per approach.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    tlc_approach_checker #(
      .MIN_GREEN (MIN_GREEN),
      .MIN_YELLOW(MIN_YELLOW),
      .CNT_W     (CNT_W)
    ) u_chk (
      .clk    (clk),
      .rst_n  (reset),
      .hold   (state_q == ST_INIT),
      .code_i (s1_q[i]),
      .illegal(illegal[i]),
      .bad_seq(bad_seq[i]),
      .short_y(short_y[i]),
      .short_g(short_g[i]),
      .not_red(not_red[i])
    );
    assign dec_g[i] = (s1_q[i] == LC_GREEN);
    assign dec_y[i] = (s1_q[i] == LC_YELLOW);
    assign dec_r[i] = (s1_q[i] == LC_RED);
  end

  assign all_red = ~|not_red;

  // Count approaches holding right-of-way (anything but red).
  always_comb begin
    nr_cnt = 0;
    for (int i = 0; i < NUM_LANES; i++) nr_cnt = nr_cnt + (not_red[i] ? 1 : 0);
  end

  assign conflict = (nr_cnt > 1);

  // Lowest fault code wins when several rules trip together.
  always_comb begin
    cause = FC_NONE;
    if (|illegal)      cause = FC_ILLEGAL;
    else if (conflict) cause = FC_CONFLICT;
    else if (|bad_seq) cause = FC_BAD_SEQ;
    else if (|short_y) cause = FC_SHORT_Y;
    else if (|short_g) cause = FC_SHORT_G;
  end

  // Monitor FSM, fault latch, flash timer and registered lamp mux.
  always_comb begin
    state_d      = state_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    lamp_g_d     = lamp_g_q;
    lamp_y_d     = lamp_y_q;
    lamp_r_d     = lamp_r_q;
    flash_cnt_d  = flash_cnt_q;
    flash_on_d   = flash_on_q;
    case (state_q)
      ST_INIT: begin
        lamp_g_d = '0;
        lamp_y_d = '0;
        lamp_r_d = '1;
        if (all_red) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cause != FC_NONE) begin
          // Offending code never reaches the lamps: fault pattern this cycle.
          state_d      = ST_FAULT;
          fault_d      = 1'b1;
          fault_code_d = cause;
          lamp_g_d     = '0;
          lamp_y_d     = '0;
          lamp_r_d     = '1;
          flash_cnt_d  = CNT_ONE;
          flash_on_d   = 1'b1;
        end else begin
          lamp_g_d = dec_g;
          lamp_y_d = dec_y;
          lamp_r_d = dec_r;
        end
      end
      ST_FAULT: begin
        lamp_g_d = '0;
        lamp_y_d = '0;
        if (fault_clr && all_red) begin
          state_d      = ST_INIT;
          fault_d      = 1'b0;
          fault_code_d = FC_NONE;
          lamp_r_d     = '1;
          flash_cnt_d  = '0;
          flash_on_d   = 1'b0;
        end else begin
          if (flash_cnt_q == FLASH_HALF_C) begin
            flash_on_d  = !flash_on_q;
            flash_cnt_d = CNT_ONE;
          end else begin
            flash_cnt_d = flash_cnt_q + CNT_ONE;
          end
          lamp_r_d = {3{flash_on_d}};
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // All monitor state; async reset returns outputs to safe all-red at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q         <= {NUM_LANES{LC_RED}};
      state_q      <= ST_INIT;
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
      lamp_g_q     <= '0;
      lamp_y_q     <= '0;
      lamp_r_q     <= '1;
      flash_cnt_q  <= '0;
      flash_on_q   <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      state_q      <= state_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      lamp_g_q     <= lamp_g_d;
      lamp_y_q     <= lamp_y_d;
      lamp_r_q     <= lamp_r_d;
      flash_cnt_q  <= flash_cnt_d;
      flash_on_q   <= flash_on_d;
    end
  end

  assign lamp_g     = lamp_g_q;
  assign lamp_y     = lamp_y_q;
  assign lamp_r     = lamp_r_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_tlc_lamp_monitor.sv
// Directed bench for tlc_lamp_monitor with default parameters
// (MIN_GREEN 8, MIN_YELLOW 4, FLASH_HALF 8, CNT_W 8).
module tb_tlc_lamp_monitor;

  localparam logic [1:0] G = 2'd0, Y = 2'd1, R = 2'd2, X = 2'd3;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] TL1, TL2, TL3;
  logic       fault_clr;
  logic [2:0] lamp_g, lamp_y, lamp_r, fault_code;
  logic       fault;
  logic [12:0] obs_w;

  int vectors = 0;
  int miscompares = 0;

  tlc_lamp_monitor dut (
    .clk       (clk),
    .reset     (reset),
    .TL1       (TL1),
    .TL2       (TL2),
    .TL3       (TL3),
    .fault_clr (fault_clr),
    .lamp_g    (lamp_g),
    .lamp_y    (lamp_y),
    .lamp_r    (lamp_r),
    .fault     (fault),
    .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  assign obs_w = {lamp_g, lamp_y, lamp_r, fault, fault_code};

  function automatic logic [12:0] ov(input logic [2:0] g, input logic [2:0] y,
                                     input logic [2:0] r, input logic f, input logic [2:0] c);
    return {g, y, r, f, c};
  endfunction

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare only the fault flag and cause.
  task automatic chkf(input string tag, input logic f, input logic [2:0] c);
    chk(tag, {9'b0, obs_w[3:0]}, {9'b0, f, c});
  endtask

  task automatic set(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    TL1 = a; TL2 = b; TL3 = c;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; fault_clr = 1'b0;
    set(R, R, R);
    #12;
    chk("reset_state", obs_w, ov(3'b000, 3'b000, 3'b111, 1'b0, 3'd0));
    tick(1); reset = 1'b1;
    tick(3);
    chk("init_to_run_all_red", obs_w, ov(3'b000, 3'b000, 3'b111, 1'b0, 3'd0));

    // Approach 1: G16 -> Y4 -> R
    set(G, R, R); tick(1);
    chk("latency_one_cycle_old", obs_w, ov(3'b000, 3'b000, 3'b111, 1'b0, 3'd0));
    tick(1);
    chk("a1_green", obs_w, ov(3'b001, 3'b000, 3'b110, 1'b0, 3'd0));
    tick(14);
    set(Y, R, R); tick(2);
    chk("a1_yellow", obs_w, ov(3'b000, 3'b001, 3'b110, 1'b0, 3'd0));
    tick(2);
    set(R, R, R); tick(2);
    chk("a1_red_min_yellow_ok", obs_w, ov(3'b000, 3'b000, 3'b111, 1'b0, 3'd0));

    // Approach 2: G16 -> Y4 -> R
    set(R, G, R); tick(2);
    chk("a2_green", obs_w, ov(3'b010, 3'b000, 3'b101, 1'b0, 3'd0));
    tick(14);
    set(R, Y, R); tick(2);
    chk("a2_yellow", obs_w, ov(3'b000, 3'b010, 3'b101, 1'b0, 3'd0));
    tick(2);
    set(R, R, R); tick(2);
    chk("a2_red", obs_w, ov(3'b000, 3'b000, 3'b111, 1'b0, 3'd0));

    // Approach 3: green exactly MIN_GREEN is legal
    set(R, R, G); tick(8);
    set(R, R, Y); tick(2);
    chk("a3_green_min_boundary", obs_w, ov(3'b000, 3'b100, 3'b011, 1'b0, 3'd0));
    tick(2);
    set(R, R, R); tick(2);
    chk("a3_red", obs_w, ov(3'b000, 3'b000, 3'b111, 1'b0, 3'd0));

    // Conflict: two greens at once, then red flash 8 on / 8 off
    set(G, G, R); tick(1);
    chk("conflict_pre", obs_w, ov(3'b000, 3'b000, 3'b111, 1'b0, 3'd0));
    tick(1);
    chk("conflict_fault", obs_w, ov(3'b000, 3'b000, 3'b111, 1'b1, 3'd2));
    tick(7);
    chk("flash_on_last", obs_w, ov(3'b000, 3'b000, 3'b111, 1'b1, 3'd2));
    tick(1);
    chk("flash_off_first", obs_w, ov(3'b000, 3'b000, 3'b000, 1'b1, 3'd2));
    tick(7);
    chk("flash_off_last", obs_w, ov(3'b000, 3'b000, 3'b000, 1'b1, 3'd2));
    tick(1);
    chk("flash_on_again", obs_w, ov(3'b000, 3'b000, 3'b111, 1'b1, 3'd2));

    // Clear refused while s1 not all red; honoured once s1 is all red
    set(G, R, R); fault_clr = 1'b1; tick(2);
    chkf("clr_refused", 1'b1, 3'd2);
    set(R, R, R); tick(1);
    chkf("clr_waits_for_s1", 1'b1, 3'd2);
    tick(1);
    chk("clr_to_init", obs_w, ov(3'b000, 3'b000, 3'b111, 1'b0, 3'd0));
    fault_clr = 1'b0; tick(1);

    // Green straight to red: bad sequence
    set(R, R, G); tick(2);
    chk("run_resumed_a3_green", obs_w, ov(3'b100, 3'b000, 3'b011, 1'b0, 3'd0));
    tick(8);
    set(R, R, R); tick(1);
    chkf("bad_seq_pre", 1'b0, 3'd0);
    tick(1);
    chk("bad_seq_fault", obs_w, ov(3'b000, 3'b000, 3'b111, 1'b1, 3'd3));
    fault_clr = 1'b1; tick(1);
    chkf("clr_bad_seq", 1'b0, 3'd0);
    fault_clr = 1'b0; tick(2);

    // Short yellow: Y for 2 then R
    set(G, R, R); tick(8);
    set(Y, R, R); tick(2);
    set(R, R, R); tick(2);
    chk("short_yellow", obs_w, ov(3'b000, 3'b000, 3'b111, 1'b1, 3'd4));
    fault_clr = 1'b1; tick(1);
    chkf("clr_short_y", 1'b0, 3'd0);
    fault_clr = 1'b0; tick(2);

    // Short green: G for 5 then Y; yellow lamp must never light
    set(G, R, R); tick(5);
    set(Y, R, R); tick(2);
    chk("short_green", obs_w, ov(3'b000, 3'b000, 3'b111, 1'b1, 3'd5));
    set(R, R, R); fault_clr = 1'b1; tick(2);
    chkf("clr_short_g", 1'b0, 3'd0);
    fault_clr = 1'b0; tick(1);

    // Illegal plus conflict together: illegal wins, cause sticks
    set(X, G, R); tick(2);
    chk("illegal_wins", obs_w, ov(3'b000, 3'b000, 3'b111, 1'b1, 3'd1));
    set(G, G, R); tick(2);
    chkf("first_cause_held", 1'b1, 3'd1);
    set(R, R, R); fault_clr = 1'b1; tick(2);
    chkf("clr_illegal", 1'b0, 3'd0);
    fault_clr = 1'b0; tick(1);

    // Long green past counter saturation, fault_clr ignored in RUN
    set(G, R, R); fault_clr = 1'b1; tick(2);
    chk("clr_ignored_in_run", obs_w, ov(3'b001, 3'b000, 3'b110, 1'b0, 3'd0));
    fault_clr = 1'b0; tick(259);
    set(Y, R, R); tick(2);
    chk("long_green_saturates", obs_w, ov(3'b000, 3'b001, 3'b110, 1'b0, 3'd0));
    tick(2);
    set(R, R, R); tick(2);
    chk("long_green_done", obs_w, ov(3'b000, 3'b000, 3'b111, 1'b0, 3'd0));

    // Async reset in the middle of the off phase of the flash
    set(R, G, G); tick(2);
    chkf("conflict2", 1'b1, 3'd2);
    tick(10);
    chk("mid_flash_off", obs_w, ov(3'b000, 3'b000, 3'b000, 1'b1, 3'd2));
    #3 reset = 1'b0;
    #1;
    chk("async_reset_immediate", obs_w, ov(3'b000, 3'b000, 3'b111, 1'b0, 3'd0));
    set(R, R, R);
    tick(1); reset = 1'b1;
    tick(3);
    chk("after_reset_run", obs_w, ov(3'b000, 3'b000, 3'b111, 1'b0, 3'd0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
